// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution feeder path.
//   DW     : element width (the engine only supports 8)
//   TILE_N : input tile elements (4x4)
//   FILT_N : filter elements (3x3)
//   ld_state_t : loader state encoding
//   elem_lsb   : LSB position of element i in a row-major flat bus
package conv_pkg;

  localparam int unsigned DW     = 8;
  localparam int unsigned TILE_N = 16;
  localparam int unsigned FILT_N = 9;

  typedef enum logic [1:0] {
    LOAD_F,
    LOAD_A,
    RUN
  } ld_state_t;

  function automatic int unsigned elem_lsb(input int unsigned i, input int unsigned w);
    return i * w;
  endfunction

endpackage

// File: rtl/conv_tile_loader.sv
// conv_tile_loader: byte-stream feeder for the single-PE 3x3 convolution engine.
// Collects 9 filter bytes then 16 tile bytes over valid/ready, holds `active`
// high until the engine signals completion, then re-arms (optionally keeping
// the filter).
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   clear           synchronous flush (drops tile, invalidates filter)
//   reuse_filter    keep the loaded filter for the next tile
//   in_valid/in_data/in_ready  byte stream handshake
//   done_in         engine completion level (rising edge is the event)
//   active          engine enable
//   a_flat, b_flat  row-major tile / filter buses (element 0 at LSB)
//   filter_loaded   a complete filter is held
//   tiles_done      wrapping count of completed tiles
module conv_tile_loader #(
  parameter int unsigned DW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              reuse_filter,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_data,
  output logic              in_ready,
  input  logic              done_in,
  output logic              active,
  output logic [16*DW-1:0]  a_flat,
  output logic [9*DW-1:0]   b_flat,
  output logic              filter_loaded,
  output logic [15:0]       tiles_done
);

  import conv_pkg::ld_state_t;
  import conv_pkg::LOAD_F;
  import conv_pkg::LOAD_A;
  import conv_pkg::RUN;
  import conv_pkg::TILE_N;
  import conv_pkg::FILT_N;
  import conv_pkg::elem_lsb;

  localparam logic [4:0] FILT_LAST = 5'(FILT_N - 1);
  localparam logic [4:0] TILE_LAST = 5'(TILE_N - 1);

  ld_state_t   state;
  ld_state_t   state_nxt;
  logic [4:0]  idx;
  logic        done_q;
  logic        done_edge;
  logic        run_done;
  logic        xfer;
  logic        last_f;
  logic        last_a;
  logic        keep_filter;
  logic [DW-1:0] a_q [TILE_N];
  logic [DW-1:0] b_q [FILT_N];

  // A clear in the same cycle as a handshake drops the byte.
  assign xfer        = in_valid & in_ready & ~clear;
  assign last_f      = xfer & (state == LOAD_F) & (idx == FILT_LAST);
  assign last_a      = xfer & (state == LOAD_A) & (idx == TILE_LAST);
  assign done_edge   = done_in & ~done_q;
  assign run_done    = (state == RUN) & done_edge;
  assign keep_filter = reuse_filter & filter_loaded;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD_F;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = LOAD_F;
    end else begin
      case (state)
        LOAD_F:  if (last_f) state_nxt = LOAD_A;
        LOAD_A:  if (last_a) state_nxt = RUN;
        RUN:     if (done_edge) state_nxt = keep_filter ? LOAD_A : LOAD_F;
        default: state_nxt = LOAD_F;
      endcase
    end
  end

  // Output decode
  always_comb begin
    in_ready = 1'b0;
    case (state)
      LOAD_F, LOAD_A: in_ready = 1'b1;
      default:        in_ready = 1'b0;
    endcase
  end

  // Control registers. The completion count advances even when a clear
  // lands on the same edge as the done edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx           <= '0;
      done_q        <= 1'b0;
      active        <= 1'b0;
      filter_loaded <= 1'b0;
      tiles_done    <= '0;
    end else begin
      done_q <= done_in;

      if (run_done) begin
        tiles_done <= tiles_done + 16'd1;
      end

      if (clear || last_f || last_a) begin
        idx <= '0;
      end else if (xfer) begin
        idx <= idx + 5'd1;
      end

      if (clear || run_done) begin
        active <= 1'b0;
      end else if (last_a) begin
        active <= 1'b1;
      end

      if (clear || (run_done && !keep_filter)) begin
        filter_loaded <= 1'b0;
      end else if (last_f) begin
        filter_loaded <= 1'b1;
      end
    end
  end

  // Holding registers, written at the slot selected by idx
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < TILE_N; i++) a_q[i] <= '0;
      for (int unsigned i = 0; i < FILT_N; i++) b_q[i] <= '0;
    end else if (xfer) begin
      for (int unsigned i = 0; i < TILE_N; i++) begin
        if ((state == LOAD_A) && ({27'd0, idx} == i)) a_q[i] <= in_data;
      end
      for (int unsigned i = 0; i < FILT_N; i++) begin
        if ((state == LOAD_F) && ({27'd0, idx} == i)) b_q[i] <= in_data;
      end
    end
  end

  // Flatten row-major
  always_comb begin
    a_flat = '0;
    b_flat = '0;
    for (int unsigned i = 0; i < TILE_N; i++) a_flat[elem_lsb(i, DW) +: DW] = a_q[i];
    for (int unsigned i = 0; i < FILT_N; i++) b_flat[elem_lsb(i, DW) +: DW] = b_q[i];
  end

endmodule

// File: doc/conv_tile_loader.md
# conv_tile_loader

Upstream feeder for the single-PE 3x3 convolution engine. Accepts a byte stream over a valid/ready handshake. Assembles a 3x3 filter (b11..b33) and a 4x4 input tile (a11..a44) into holding registers. It then holds `active` high until the engine reports completion, and re-arms for the next tile, optionally reusing the loaded filter.

## Interface
Parameters:
- `DW`, default 8: element width; the engine is fixed at 8, other values are unsupported.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `clear`  in  1  synchronous flush: abandon the current tile and invalidate the filter.
- `reuse_filter`  in  1  keep the current filter for the next tile.
- `in_valid`  in  1  stream byte valid.
- `in_data`  in  DW  stream byte.
- `in_ready`  out  1  loader can accept a byte.
- `done_in`  in  1  completion from the engine; treated as a level and edge-detected internally.
- `active`  out  1  engine enable; drives the engine's `active_single`.
- `a_flat`  out  16*DW  tile, row-major: a11 at [7:0], a12 at [15:8] … a44 at [127:120].
- `b_flat`  out  9*DW  filter, row-major: b11 at [7:0] … b33 at [71:64].
- `filter_loaded`  out  1  a complete filter is held.
- `tiles_done`  out  16  count of completed tiles; wraps at 65535 → 0.

## Operation
States:
- **LOAD_F**: accept 9 filter bytes, ordered b11,b12,b13,b21,…,b33.
- **LOAD_A**: accept 16 tile bytes, ordered a11,a12,…,a44.
- **RUN**: wait for the engine.

Handshake and counting:
- `in_ready` = 1 in LOAD_F and LOAD_A, 0 in RUN; it is a combinational decode of the state.
- A byte transfers when `in_valid & in_ready`. It is written to the register selected by a 5-bit byte counter `idx`, which then increments.
- `in_valid` with `in_ready` = 0 is ignored; no data is lost, because the producer holds the byte.

Transitions:
- **LOAD_F → LOAD_A**: on acceptance of filter byte 9, i.e. `idx` = 8. `idx` ← 0 and `filter_loaded` ← 1.
- **LOAD_A → RUN**: on acceptance of tile byte 16, i.e. `idx` = 15. `idx` ← 0.
- **RUN**:
  - `active` = 1 (registered).
  - `a_flat` and `b_flat` are frozen.
  - A done edge is the condition `done_in` = 1 while `done_q` = 0, where `done_q` is `done_in` delayed one cycle.
  - On a done edge: `tiles_done` += 1, `active` ← 0, and the next state is LOAD_A if `reuse_filter` & `filter_loaded`, otherwise LOAD_F.
  - In the LOAD_F case `filter_loaded` ← 0 at the same edge.
- **clear**, in any state: state ← LOAD_F, `idx` ← 0, `active` ← 0, `filter_loaded` ← 0. `tiles_done` is kept, and data registers keep stale contents.
- **clear coinciding with a done edge**: clear wins, and `tiles_done` still increments.
- **clear coinciding with a byte transfer**: the byte is dropped.
- A `done_in` held high continuously produces exactly one completion. A `done_in` level stuck high from the previous run produces no edge, so the next RUN waits for low→high.
- `done_in` seen outside RUN only updates `done_q`.

## Timing
- **Reset values**: state LOAD_F, `in_ready` 1, `active` 0, `a_flat` 0, `b_flat` 0, `filter_loaded` 0, `tiles_done` 0, `idx` 0, `done_q` 0.
- **Load latency**: with `in_valid` held high, `active` rises on the clock edge that accepts the last tile byte. That is 25 cycles from the first accepted byte for a full load, or 16 with filter reuse.
- **Release latency**: `active` falls on the clock edge where the done edge is sampled. `in_ready` is high the same cycle after that edge.
- **Register writes**: data registers update on the accepting edge and are visible the next cycle.
- **Reset mid-load or mid-run**: immediate return to the reset values, with no handshake completion.

## Structure
- Shared package `conv_pkg`:
  - `DW` = 8, `TILE_N` = 16, `FILT_N` = 9.
  - State enum `ld_state_t` {LOAD_F, LOAD_A, RUN}.
  - Flat-bus index helpers.
- Single module: the byte-write decode, counters and edge detector are inline.
- No sub-module is natural; the engine is instantiated by the parent, not here.

## Test plan
- **Full load**: reset, stream filter 1..9 then tile 10..25 with `in_valid` always high.
  - `b_flat[7:0]` = 1, `b_flat[71:64]` = 9, `a_flat[7:0]` = 10, `a_flat[127:120]` = 25.
  - `active` rises after the 25th accept and `in_ready` = 0.
- **Backpressure and gaps**: toggle `in_valid` randomly, and drive `in_valid` high during RUN.
  - Registers match the accepted order exactly.
  - No writes occur in RUN; `a_flat` is unchanged.
- **Done handling**: pulse `done_in` for 1 cycle in RUN.
  - `active` falls the next edge and `tiles_done` = 1.
  - A second test holds `done_in` high 5 cycles and then reloads: the next RUN does not exit until `done_in` goes low then high again.
- **Filter reuse**: complete one tile, then assert `reuse_filter`.
  - The next state is LOAD_A, and only 16 bytes are needed for `active`.
  - `b_flat` is unchanged; with `reuse_filter` = 0 the loader requires 25 bytes.
- **Clear and reset mid-operation**:
  - Clear after 12 bytes: state LOAD_F, `filter_loaded` 0, and a full 25-byte reload is required.
  - Clear coinciding with a done edge: `tiles_done` increments and state is LOAD_F.
  - Async `rst` during RUN: `active` 0 immediately and all outputs at their reset values.
- **Counter wrap**: preload `tiles_done` near the limit (force or 65535 runs): 65535 → 0 on the next completion.
